// File: rtl/ofdm_bit_encoder_if.sv
// Handshake and configuration bundle between the MAC / TX interleaver side and ofdm_bit_encoder.
interface ofdm_bit_encoder_if #(
    parameter int NUM_BITS_W = 20
);
    logic                  enable;
    logic                  start;
    logic [7:0]            rate;
    logic                  do_scramble;
    logic [6:0]            scram_seed;
    logic [15:0]           num_bytes;
    logic [NUM_BITS_W-1:0] num_bits_to_encode;
    logic [7:0]            byte_in;
    logic                  byte_in_strobe;
    logic                  byte_in_ready;
    logic                  coded_bit;
    logic                  coded_bit_strobe;
    logic                  coded_bit_ready;
    logic                  busy;
    logic                  done;

    modport master (
        output enable, start, rate, do_scramble, scram_seed, num_bytes,
               num_bits_to_encode, byte_in, byte_in_strobe, coded_bit_ready,
        input  byte_in_ready, coded_bit, coded_bit_strobe, busy, done
    );

    modport slave (
        input  enable, start, rate, do_scramble, scram_seed, num_bytes,
               num_bits_to_encode, byte_in, byte_in_strobe, coded_bit_ready,
        output byte_in_ready, coded_bit, coded_bit_strobe, busy, done
    );
endinterface

// File: rtl/ofdm_bit_encoder.sv
// TX bit pipeline: byte serialize, SERVICE/tail/pad insert, scramble, K=7 conv encode, puncture.
// First coded bit 2 cycles after start; one uncoded bit issued only when the 2-entry output FIFO has room.
module ofdm_bit_encoder #(
    parameter int NUM_BITS_W = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    ofdm_bit_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SERVICE, S_DATA, S_TAIL, S_PAD, S_FLUSH
    } state_t;

    typedef enum logic [1:0] {RATE_12, RATE_23, RATE_34} rate_t;

    localparam logic [NUM_BITS_W-1:0] BITS_ONE = 1;

    state_t                r_state, w_state_nxt;
    rate_t                 r_rate, w_rate_dec;
    logic                  r_scr_en;
    logic [15:0]           r_num_bytes;
    logic [NUM_BITS_W-1:0] r_num_bits, r_bit_count;
    logic [18:0]           r_sub_cnt;
    logic [1:0]            r_phase;
    logic [6:0]            r_scr;
    logic [5:0]            r_conv;
    logic [7:0]            r_sr;
    logic [3:0]            r_sr_cnt;
    logic [1:0]            r_fifo, w_fifo_nxt;
    logic [1:0]            r_fifo_cnt, w_fifo_cnt_nxt, w_base;
    logic                  r_done;

    logic        w_en, w_start, w_at_limit, w_issue_state, w_byte_rdy, w_byte_acc;
    logic        w_pop, w_push_two, w_have_bit, w_issue, w_last;
    logic [2:0]  w_fill;
    logic        w_data_bit, w_raw_bit, w_fb, w_scr_bit, w_enc_in, w_a, w_b, w_first;
    logic [18:0] w_data_end;
    logic        w_unused_rate;

    assign w_unused_rate = ^bus.rate[7:4];

    always_comb begin
        w_rate_dec = RATE_12;
        case (bus.rate[3:0])
            4'h8:                   w_rate_dec = RATE_23;
            4'hC, 4'hD, 4'hE, 4'hF: w_rate_dec = RATE_34;
            default:                w_rate_dec = RATE_12;
        endcase
    end

    assign w_en          = bus.enable;
    assign w_start       = w_en && bus.start && (r_state == S_IDLE);
    assign w_at_limit    = (r_bit_count == r_num_bits);
    assign w_issue_state = (r_state == S_SERVICE) || (r_state == S_DATA) ||
                           (r_state == S_TAIL)    || (r_state == S_PAD);
    assign w_byte_rdy    = (r_state == S_DATA) && (r_sr_cnt == 4'd0) && !w_at_limit;
    assign w_byte_acc    = w_en && bus.byte_in_strobe && w_byte_rdy;
    assign w_pop         = w_en && (r_fifo_cnt != 2'd0) && bus.coded_bit_ready;

    // Push count depends on puncture phase; the issue is gated so the FIFO never exceeds 2 entries.
    assign w_push_two = (r_rate == RATE_12) || (r_phase == 2'd0);
    assign w_fill     = {1'b0, r_fifo_cnt} + (w_push_two ? 3'd2 : 3'd1) - {2'b00, w_pop};
    assign w_have_bit = (r_state != S_DATA) || (r_sr_cnt != 4'd0) || w_byte_acc;
    assign w_issue    = w_en && w_issue_state && !w_at_limit && (w_fill <= 3'd2) && w_have_bit;

    // An empty shift register lets the incoming byte's LSB go straight through.
    assign w_data_bit = (r_sr_cnt != 4'd0) ? r_sr[0] : bus.byte_in[0];
    assign w_raw_bit  = (r_state == S_DATA) && w_data_bit;
    assign w_fb       = r_scr[6] ^ r_scr[3];
    assign w_scr_bit  = r_scr_en ? (w_raw_bit ^ w_fb) : w_raw_bit;
    assign w_enc_in   = (r_state != S_TAIL) && w_scr_bit;
    assign w_a        = w_enc_in ^ r_conv[1] ^ r_conv[2] ^ r_conv[4] ^ r_conv[5];
    assign w_b        = w_enc_in ^ r_conv[0] ^ r_conv[1] ^ r_conv[2] ^ r_conv[5];
    assign w_first    = ((r_rate == RATE_34) && (r_phase == 2'd2)) ? w_b : w_a;

    assign w_data_end = {r_num_bytes, 3'b000} - 19'd1;

    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_SERVICE: w_last = (r_sub_cnt == 19'd15);
            S_DATA:    w_last = (r_sub_cnt == w_data_end);
            S_TAIL:    w_last = (r_sub_cnt == 19'd5);
            default:   w_last = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (bus.do_scramble)             w_state_nxt = S_SERVICE;
                    else if (bus.num_bytes != 16'd0) w_state_nxt = S_DATA;
                    else                             w_state_nxt = S_PAD;
                end
            end
            S_SERVICE: begin
                if (w_en && w_at_limit)    w_state_nxt = S_FLUSH;
                else if (w_issue && w_last) w_state_nxt = (r_num_bytes != 16'd0) ? S_DATA : S_TAIL;
            end
            S_DATA: begin
                if (w_en && w_at_limit)    w_state_nxt = S_FLUSH;
                else if (w_issue && w_last) w_state_nxt = r_scr_en ? S_TAIL : S_PAD;
            end
            S_TAIL: begin
                if (w_en && w_at_limit)    w_state_nxt = S_FLUSH;
                else if (w_issue && w_last) w_state_nxt = S_PAD;
            end
            S_PAD: begin
                if (w_en && w_at_limit) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_en && (r_fifo_cnt == 2'd0)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Head of the FIFO is entry 0; a push lands behind whatever survives this cycle's pop.
    always_comb begin
        w_fifo_nxt     = r_fifo;
        w_base         = r_fifo_cnt;
        w_fifo_cnt_nxt = r_fifo_cnt;
        if (w_pop) begin
            w_fifo_nxt = {1'b0, r_fifo[1]};
            w_base     = r_fifo_cnt - 2'd1;
        end
        w_fifo_cnt_nxt = w_base;
        if (w_issue) begin
            if (w_base == 2'd0) begin
                w_fifo_nxt[0] = w_first;
                if (w_push_two) w_fifo_nxt[1] = w_b;
            end else begin
                w_fifo_nxt[1] = w_first;
            end
            w_fifo_cnt_nxt = w_base + (w_push_two ? 2'd2 : 2'd1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rate      <= RATE_12;
            r_scr_en    <= 1'b0;
            r_num_bytes <= '0;
            r_num_bits  <= '0;
            r_bit_count <= '0;
            r_sub_cnt   <= '0;
            r_phase     <= '0;
            r_scr       <= '0;
            r_conv      <= '0;
            r_sr        <= '0;
            r_sr_cnt    <= '0;
            r_fifo      <= '0;
            r_fifo_cnt  <= '0;
            r_done      <= 1'b0;
        end else if (w_en) begin
            r_fifo     <= w_fifo_nxt;
            r_fifo_cnt <= w_fifo_cnt_nxt;
            r_done     <= (r_state == S_FLUSH) && (r_fifo_cnt == 2'd0);
            if (w_start) begin
                r_rate      <= w_rate_dec;
                r_scr_en    <= bus.do_scramble;
                r_num_bytes <= bus.num_bytes;
                r_num_bits  <= bus.num_bits_to_encode;
                r_bit_count <= '0;
                r_sub_cnt   <= '0;
                r_phase     <= '0;
                r_scr       <= (bus.scram_seed == 7'd0) ? 7'h7F : bus.scram_seed;
                r_conv      <= '0;
                r_sr        <= '0;
                r_sr_cnt    <= '0;
            end else begin
                if (w_issue && (r_state == S_DATA)) begin
                    if (r_sr_cnt != 4'd0) begin
                        r_sr     <= {1'b0, r_sr[7:1]};
                        r_sr_cnt <= r_sr_cnt - 4'd1;
                    end else begin
                        r_sr     <= {1'b0, bus.byte_in[7:1]};
                        r_sr_cnt <= 4'd7;
                    end
                end else if (w_byte_acc) begin
                    r_sr     <= bus.byte_in;
                    r_sr_cnt <= 4'd8;
                end
                if (w_issue) begin
                    r_bit_count <= r_bit_count + BITS_ONE;
                    r_sub_cnt   <= w_last ? 19'd0 : r_sub_cnt + 19'd1;
                    r_conv      <= {r_conv[4:0], w_enc_in};
                    if (r_scr_en) r_scr <= {r_scr[5:0], w_fb};
                    case (r_rate)
                        RATE_23: r_phase <= (r_phase == 2'd0) ? 2'd1 : 2'd0;
                        RATE_34: r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
                        default: r_phase <= 2'd0;
                    endcase
                end
            end
        end
    end

    assign bus.byte_in_ready    = w_byte_rdy;
    assign bus.coded_bit        = r_fifo[0];
    assign bus.coded_bit_strobe = (r_fifo_cnt != 2'd0);
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.done             = r_done;
endmodule

// File: tb/tb_ofdm_bit_encoder.sv
// Directed bench for ofdm_bit_encoder: impulse, scrambled SERVICE, puncturing, stalls, mid-frame reset.
module tb_ofdm_bit_encoder;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ofdm_bit_encoder_if #(.NUM_BITS_W(20)) bus ();
    ofdm_bit_encoder #(.NUM_BITS_W(20)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_bytes [0:15];
    logic       got_bits [0:511];
    int         got_n, done_cnt, latency, stab_viol;
    logic       exp_bits [0:511];
    int         exp_n;
    logic       u_bits   [0:255];
    int         u_n;

    // Uncoded stream written left-to-right as it would be transmitted.
    task automatic set_uncoded(input logic [255:0] v, input int n);
        u_n = n;
        for (int i = 0; i < n; i++) u_bits[i] = v[n-1-i];
    endtask

    task automatic set_uncoded_bytes(input int nbytes, input int nbits);
        u_n = nbits;
        for (int i = 0; i < nbits; i++)
            u_bits[i] = (i < 8*nbytes) ? tx_bytes[i/8][i%8] : 1'b0;
    endtask

    function automatic logic ub(input int i);
        return (i < 0) ? 1'b0 : u_bits[i];
    endfunction

    // Convolution with the generator taps, then puncture (rsel 0=1/2, 1=2/3, 2=3/4).
    task automatic ref_encode(input int rsel);
        logic a, b;
        exp_n = 0;
        for (int t = 0; t < u_n; t++) begin
            a = ub(t) ^ ub(t-2) ^ ub(t-3) ^ ub(t-5) ^ ub(t-6);
            b = ub(t) ^ ub(t-1) ^ ub(t-2) ^ ub(t-3) ^ ub(t-6);
            if (rsel == 0 || (t % (rsel+1)) == 0) begin
                exp_bits[exp_n] = a; exp_bits[exp_n+1] = b; exp_n += 2;
            end else if (rsel == 1 || (t % 3) == 1) begin
                exp_bits[exp_n] = a; exp_n++;
            end else begin
                exp_bits[exp_n] = b; exp_n++;
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_n < exp_n) ? got_n : exp_n;
        for (int i = 0; i < n; i++)
            if (got_bits[i] !== exp_bits[i]) return i;
        return (got_n == exp_n) ? -1 : n;
    endfunction

    task automatic run_frame(input logic [7:0] rate, input logic scr, input logic [6:0] seed,
                             input logic [15:0] nbytes, input logic [19:0] nbits,
                             input bit stall, input int abort_at);
        int   bidx, after_done;
        logic prev_hold, prev_bit, prev_done;
        bit   en, rdy, str;
        got_n = 0; done_cnt = 0; latency = -1; stab_viol = 0;
        bidx = 0; after_done = 0; prev_hold = 0; prev_bit = 0; prev_done = 0;
        @(negedge clock);
        bus.rate = rate; bus.do_scramble = scr; bus.scram_seed = seed;
        bus.num_bytes = nbytes; bus.num_bits_to_encode = nbits;
        bus.enable = 1'b1; bus.start = 1'b1; bus.coded_bit_ready = 1'b1;
        bus.byte_in = tx_bytes[0]; bus.byte_in_strobe = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clock);
            bus.start = stall && (cyc == 10);
            if (stall && cyc == 10) begin
                bus.rate = 8'h0B; bus.num_bits_to_encode = 20'd24; bus.do_scramble = 1'b1;
            end
            if (cyc == abort_at) return;
            if (prev_hold && (bus.coded_bit_strobe !== 1'b1 || bus.coded_bit !== prev_bit))
                stab_viol++;
            if (latency < 0 && bus.coded_bit_strobe === 1'b1) latency = cyc;
            if (bus.done === 1'b1 && !prev_done) done_cnt++;
            prev_done = bus.done;
            if (done_cnt > 0) after_done++;
            if (after_done > 3) break;
            en  = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
            rdy = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
            str = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.enable = en; bus.coded_bit_ready = rdy; bus.byte_in_strobe = str;
            bus.byte_in = str ? tx_bytes[bidx % 16] : ~tx_bytes[bidx % 16];
            if (en && rdy && bus.coded_bit_strobe === 1'b1 && got_n < 512) begin
                got_bits[got_n] = bus.coded_bit;
                got_n++;
            end
            if (en && str && bus.byte_in_ready === 1'b1) bidx++;
            prev_hold = (bus.coded_bit_strobe === 1'b1) && !(en && rdy);
            prev_bit  = bus.coded_bit;
        end
        bus.enable = 1'b1; bus.start = 1'b0; bus.byte_in_strobe = 1'b0; bus.coded_bit_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if (bus.byte_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_byte_rdy: got %b want 0", bus.byte_in_ready); end
        n_cmp++; if (bus.coded_bit !== 1'b0) begin n_bad++; $display("FAIL rst_coded_bit: got %b want 0", bus.coded_bit); end
        n_cmp++; if (bus.coded_bit_strobe !== 1'b0) begin n_bad++; $display("FAIL rst_strobe: got %b want 0", bus.coded_bit_strobe); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        reset_n = 1'b1;
        bus.enable = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.coded_bit_strobe !== 1'b0) begin n_bad++; $display("FAIL idle_strobe: got %b want 0", bus.coded_bit_strobe); end
    endtask

    task automatic test_rate12_impulse();
        logic [13:0] head;
        int nz;
        tx_bytes[0] = 8'h01;
        run_frame(8'h0B, 1'b0, 7'h00, 16'd1, 20'd24, 1'b0, 0);
        head = '0; nz = 0;
        for (int i = 0; i < 14; i++) head = {head[12:0], got_bits[i]};
        for (int i = 14; i < 48; i++) if (got_bits[i] !== 1'b0) nz++;
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL r12_done: got %0d pulses want 1", done_cnt); end
        n_cmp++; if (got_n !== 48) begin n_bad++; $display("FAIL r12_count: got %0d want 48", got_n); end
        n_cmp++; if (latency !== 2) begin n_bad++; $display("FAIL r12_latency: got %0d want 2", latency); end
        n_cmp++; if (head !== 14'b11011111001011) begin n_bad++; $display("FAIL r12_head: got %b want 11011111001011", head); end
        n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL r12_tail_zero: got %0d nonzero bits want 0", nz); end
    endtask

    task automatic test_scrambled_service();
        int d;
        set_uncoded(256'b0000_1110_1111_0010_0000_0001, 24);
        ref_encode(0);
        run_frame(8'h0B, 1'b1, 7'h7F, 16'd0, 20'd24, 1'b0, 0);
        d = first_diff();
        n_cmp++; if (got_n !== 48) begin n_bad++; $display("FAIL scr_count: got %0d want 48", got_n); end
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL scr_stream: first diff at bit %0d (got_n %0d want %0d)", d, got_n, exp_n); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL scr_done: got %0d pulses want 1", done_cnt); end
        run_frame(8'h0B, 1'b1, 7'h00, 16'd0, 20'd24, 1'b0, 0);
        d = first_diff();
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL scr_seed0_stream: first diff at bit %0d (got_n %0d want %0d)", d, got_n, exp_n); end
    endtask

    task automatic test_rate34_truncate();
        logic [3:0] bits;
        tx_bytes[0] = 8'h01;
        run_frame(8'h0F, 1'b0, 7'h00, 16'd1, 20'd3, 1'b0, 0);
        bits = {got_bits[0], got_bits[1], got_bits[2], got_bits[3]};
        n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL r34_count: got %0d want 4", got_n); end
        n_cmp++; if (bits !== 4'b1101) begin n_bad++; $display("FAIL r34_bits: got %b want 1101", bits); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL r34_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_rate23();
        int d;
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        set_uncoded_bytes(2, 48);
        ref_encode(1);
        run_frame(8'h08, 1'b0, 7'h00, 16'd2, 20'd48, 1'b0, 0);
        d = first_diff();
        n_cmp++; if (got_n !== 72) begin n_bad++; $display("FAIL r23_count: got %0d want 72", got_n); end
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL r23_stream: first diff at bit %0d", d); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL r23_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_back_to_back_stall();
        int d;
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        set_uncoded_bytes(2, 48);
        ref_encode(1);
        run_frame(8'h08, 1'b0, 7'h00, 16'd2, 20'd48, 1'b1, 0);
        d = first_diff();
        n_cmp++; if (got_n !== 72) begin n_bad++; $display("FAIL stall_count: got %0d want 72", got_n); end
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL stall_stream: first diff at bit %0d", d); end
        n_cmp++; if (stab_viol !== 0) begin n_bad++; $display("FAIL stall_stability: got %0d violations want 0", stab_viol); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stall_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_reset_midframe();
        int d, dseen;
        tx_bytes[0] = 8'h01;
        run_frame(8'h0B, 1'b0, 7'h00, 16'd1, 20'd24, 1'b0, 30);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.coded_bit_strobe !== 1'b0) begin n_bad++; $display("FAIL mid_rst_strobe: got %b want 0", bus.coded_bit_strobe); end
        n_cmp++; if (bus.coded_bit !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bit: got %b want 0", bus.coded_bit); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.byte_in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_byte_rdy: got %b want 0", bus.byte_in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        bus.start = 1'b0;
        dseen = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.done !== 1'b0) dseen++;
        end
        n_cmp++; if (dseen !== 0) begin n_bad++; $display("FAIL mid_rst_no_done: got %0d done cycles want 0", dseen); end
        set_uncoded(256'h800000, 24);
        ref_encode(0);
        run_frame(8'h0B, 1'b0, 7'h00, 16'd1, 20'd24, 1'b0, 0);
        d = first_diff();
        n_cmp++; if (got_n !== 48) begin n_bad++; $display("FAIL rerun_count: got %0d want 48", got_n); end
        n_cmp++; if (d !== -1) begin n_bad++; $display("FAIL rerun_stream: first diff at bit %0d", d); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rerun_done: got %0d pulses want 1", done_cnt); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0; bus.start = 1'b0; bus.rate = 8'h0B; bus.do_scramble = 1'b0;
        bus.scram_seed = 7'h00; bus.num_bytes = 16'd0; bus.num_bits_to_encode = 20'd0;
        bus.byte_in = 8'h00; bus.byte_in_strobe = 1'b0; bus.coded_bit_ready = 1'b0;
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;
        test_reset();
        test_rate12_impulse();
        test_scrambled_service();
        test_rate34_truncate();
        test_rate23();
        test_back_to_back_stall();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
